// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth product accumulator.
package booth_pkg;

  // Frame state: collecting terms, or holding a finished result.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Default widths: Booth product term and accumulator.
  localparam int PROD_W = 8;
  localparam int ACC_W  = 16;

  // Signed extremes of the default accumulator width.
  localparam logic [ACC_W-1:0] ACC_SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_SMIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/booth_prod_accum_sat_adder.sv
// Signed W-bit adder with overflow detect and optional clamp to signed max/min.
module sat_adder #(
  parameter int W   = 16,
  parameter bit SAT = 1'b0
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  logic [W:0] w_full;
  logic       w_ovf;

  // Add at W+1 bits; the extra bit is the true sign, so a mismatch with bit W-1
  // means the W-bit result left the representable range (same-sign operands,
  // different-sign result).
  always_comb begin
    w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};
    w_ovf  = w_full[W] ^ w_full[W-1];
    o_ovf  = w_ovf;
    if (w_ovf && SAT) begin
      if (w_full[W]) begin
        o_sum = {1'b1, {(W-1){1'b0}}};
      end else begin
        o_sum = {1'b0, {(W-1){1'b1}}};
      end
    end else begin
      o_sum = w_full[W-1:0];
    end
  end

endmodule

// File: rtl/booth_prod_accum.sv
// Frame accumulator for signed Booth products: sums terms over a valid/ready
// stream and presents one registered {sum, count, overflow} result per frame.
module booth_prod_accum
  import booth_pkg::*;
#(
  parameter int PW        = PROD_W,
  parameter int AW        = ACC_W,
  parameter int CW        = 8,
  parameter int MAX_TERMS = 255,
  parameter bit SAT       = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [CW-1:0] out_count,
  output logic          out_ovf
);

  state_t        r_state;
  logic          r_live;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_out_valid;
  logic [AW-1:0] r_out_sum;
  logic [CW-1:0] r_out_count;
  logic          r_out_ovf;

  logic [AW-1:0] w_term;
  logic [AW-1:0] w_sum;
  logic          w_add_ovf;
  logic [CW-1:0] w_cnt_inc;
  logic          w_cap;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_frame_end;

  // Sign-extend the product term to accumulator width.
  assign w_term = AW'($signed(in_prod));

  sat_adder #(
    .W   (AW),
    .SAT (SAT)
  ) u_add (
    .i_a   (r_acc),
    .i_b   (w_term),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  // Ready depends only on registered state and clr, never on in_valid;
  // r_live keeps it low until the first clock after reset release.
  assign w_cnt_inc   = r_count + CW'(1);
  assign w_cap       = (w_cnt_inc == CW'(MAX_TERMS));
  assign w_in_ready  = r_live & (r_state == ACCUM) & ~clr;
  assign w_accept    = in_valid & w_in_ready;
  assign w_frame_end = in_last | w_cap;

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

  // Frame FSM: accumulate accepted terms, latch the result at frame end,
  // then hold it until taken (or dropped by clr).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_live      <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ACCUM: begin
          if (clr) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
          end else if (w_accept) begin
            if (w_frame_end) begin
              r_out_sum   <= w_sum;
              r_out_count <= w_cnt_inc;
              r_out_ovf   <= r_ovf | w_add_ovf;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_count     <= '0;
              r_ovf       <= 1'b0;
              r_state     <= DONE;
            end else begin
              r_acc   <= w_sum;
              r_count <= w_cnt_inc;
              r_ovf   <= r_ovf | w_add_ovf;
            end
          end else begin
            r_acc   <= r_acc;
            r_count <= r_count;
            r_ovf   <= r_ovf;
          end
        end
        DONE: begin
          if (clr || out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
          end else begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ACCUM;
        end
      endcase
    end
  end

endmodule
